// File: rtl/screen_mem.sv
// Frame-buffer responder: pipelined screen read port, single-cycle CPU port, hardware clear sweep.
// Define SCREEN_MEM_FWD_EN to forward a same-cycle write into a colliding screen read.
module screen_mem #(
   parameter int AW      = 13,
   parameter int DW      = 16,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_ce,
   input  logic [AW-1:0] mem_addr,
   output logic          mem_vld,
   output logic [DW-1:0] mem_dat,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   input  logic          clr,
   output logic          busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] ram [0:(1<<AW)-1];

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;

   logic [LATENCY:1] vld_q, vld_d;
   logic [DW-1:0]    dat_q [1:LATENCY];
   logic [DW-1:0]    dat_d [1:LATENCY];
   logic [DW-1:0]    cpu_dout_q, cpu_dout_d;

   assign busy     = (state_q == CLEAR);
   assign mem_vld  = vld_q[LATENCY];
   assign mem_dat  = dat_q[LATENCY];
   assign cpu_dout = cpu_dout_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            // counter parks at the last address rather than wrapping
            if (cnt_q == '1) state_d = IDLE;
            else             cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single write port shared by the sweep and the CPU; the CPU loses while sweeping.
   always_comb begin
      if (busy) begin
         wr_en   = 1'b1;
         wr_addr = cnt_q;
         wr_data = '0;
      end else begin
         wr_en   = cpu_we;
         wr_addr = cpu_addr;
         wr_data = cpu_din;
      end
   end

`ifdef SCREEN_MEM_FWD_EN
   assign rd_data = (wr_en && (wr_addr == mem_addr)) ? wr_data : ram[mem_addr];
`else
   assign rd_data = ram[mem_addr];
`endif

   always_comb begin
      vld_d    = '0;
      vld_d[1] = mem_ce;
      dat_d[1] = mem_ce ? rd_data : dat_q[1];
      for (int i = 2; i <= LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   assign cpu_dout_d = cpu_re ? ram[cpu_addr] : cpu_dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         vld_q      <= '0;
         cpu_dout_q <= '0;
         for (int i = 1; i <= LATENCY; i++) dat_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
         cpu_dout_q <= cpu_dout_d;
         for (int i = 1; i <= LATENCY; i++) dat_q[i] <= dat_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_screen_mem.sv
// Directed self-checking bench for screen_mem (AW=13, DW=16, LATENCY=2).
module tb_screen_mem;
   localparam int AW = 13;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_ce;
   logic [AW-1:0] mem_addr;
   logic          mem_vld;
   logic [DW-1:0] mem_dat;
   logic          cpu_we, cpu_re;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          clr;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   screen_mem #(.AW(AW), .DW(DW), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_dat(mem_dat),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .clr(clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
      step();
      cpu_we = 1'b0;
   endtask

   task automatic scr_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      mem_ce = 1'b1; mem_addr = a;
      step();
      mem_ce = 1'b0;
      step();
      chk({tag, "_vld"}, mem_vld, 1);
      chk({tag, "_dat"}, mem_dat, exp);
   endtask

   task automatic cpu_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      cpu_re = 1'b1; cpu_addr = a;
      step();
      cpu_re = 1'b0;
      chk(tag, cpu_dout, exp);
   endtask

   task automatic fill_all(input logic [DW-1:0] d);
      for (int a = 0; a < (1 << AW); a++) wr(AW'(a), d);
   endtask

   initial begin
      int n;
      rst = 1'b1; mem_ce = 1'b0; mem_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0;
      cpu_addr = '0; cpu_din = '0; clr = 1'b0;
      @(negedge clk);
      chk("rst_vld", mem_vld, 0);
      chk("rst_dat", mem_dat, 0);
      chk("rst_dout", cpu_dout, 0);
      chk("rst_busy", busy, 0);
      step();
      rst = 1'b0;
      step();

      // Back-to-back reads of both address extremes
      wr(13'd0, 16'hA5A5);
      wr(13'd8191, 16'h1234);
      mem_ce = 1'b1; mem_addr = 13'd0;
      step();
      mem_addr = 13'd8191;
      chk("b2b_lat1", mem_vld, 0);
      step();
      mem_ce = 1'b0;
      chk("b2b_vld0", mem_vld, 1);
      chk("b2b_dat0", mem_dat, 16'hA5A5);
      step();
      chk("b2b_vld1", mem_vld, 1);
      chk("b2b_dat1", mem_dat, 16'h1234);
      step();
      chk("b2b_end", mem_vld, 0);
      chk("b2b_hold", mem_dat, 16'h1234);

      // 64-deep burst, data = address
      for (int a = 0; a < 64; a++) wr(AW'(a), DW'(a));
      n = 0;
      for (int k = 0; k < 66; k++) begin
         mem_ce = (k < 64); mem_addr = AW'(k);
         step();
         chk("burst_vld", mem_vld, (k >= 1 && k <= 64) ? 1 : 0);
         if (mem_vld) begin
            chk("burst_dat", mem_dat, n);
            n++;
         end
      end
      mem_ce = 1'b0;
      chk("burst_count", n, 64);

      // Same-cycle CPU write and screen read of one address
      wr(13'd100, 16'h0001);
      cpu_we = 1'b1; cpu_addr = 13'd100; cpu_din = 16'hBEEF;
      mem_ce = 1'b1; mem_addr = 13'd100;
      step();
      cpu_we = 1'b0; mem_ce = 1'b0;
      step();
      chk("coll_vld", mem_vld, 1);
`ifdef SCREEN_MEM_FWD_EN
      chk("coll_dat", mem_dat, 16'hBEEF);
`else
      chk("coll_dat", mem_dat, 16'h0001);
`endif
      cpu_read("coll_after", 13'd100, 16'hBEEF);

      // CPU read-before-write on one address
      wr(13'd7, 16'h0007);
      cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 13'd7; cpu_din = 16'h7777;
      step();
      cpu_we = 1'b0; cpu_re = 1'b0;
      chk("rbw_old", cpu_dout, 16'h0007);
      step();
      chk("dout_hold", cpu_dout, 16'h0007);
      cpu_read("rbw_new", 13'd7, 16'h7777);

      // Full clear sweep with a dropped write and an ignored restart
      fill_all(16'hFFFF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      n = 0;
      while (busy && n < 10000) begin
         cpu_we = (n == 100); cpu_addr = 13'd5; cpu_din = 16'h5555;
         clr = (n == 200);
         step();
         n++;
      end
      cpu_we = 1'b0; clr = 1'b0;
      chk("clr_busy_cycles", n, 8192);
      chk("clr_busy_low", busy, 0);
      scr_read("clr_rd5", 13'd5, 16'h0000);
      scr_read("clr_rd0", 13'd0, 16'h0000);
      scr_read("clr_rd4096", 13'd4096, 16'h0000);
      scr_read("clr_rd8191", 13'd8191, 16'h0000);
      cpu_read("clr_cpu5", 13'd5, 16'h0000);

      // Reset with reads in flight
      mem_ce = 1'b1; mem_addr = 13'd10;
      step(); step(); step();
      rst = 1'b1; mem_ce = 1'b0;
      #1;
      chk("rstfl_vld_now", mem_vld, 0);
      step();
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (mem_vld) n++;
      end
      chk("rstfl_no_vld", n, 0);

      // Reset partway through a sweep
      fill_all(16'hFFFF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 4000; k++) step();
      rst = 1'b1;
      #1;
      chk("rstclr_busy", busy, 0);
      step();
      rst = 1'b0;
      step();
      chk("rstclr_busy_after", busy, 0);
      chk("rstclr_vld", mem_vld, 0);
      scr_read("rstclr_3999", 13'd3999, 16'h0000);
      scr_read("rstclr_4001", 13'd4001, 16'hFFFF);
      cpu_read("rstclr_cpu0", 13'd0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
